// File: rtl/tdma_pkg.sv
// Types shared between the tensor-DMA frontend, the burst splitter and the backend.
// The widths here are the default system configuration.
package tdma_pkg;

  localparam int unsigned TdmaAddrWidth = 64;
  localparam int unsigned TdmaLenWidth  = 32;
  localparam int unsigned TdmaPageBytes = 4096;
  localparam int unsigned TdmaChunkLenW = $clog2(TdmaPageBytes) + 1;

  typedef struct packed {
    logic [TdmaAddrWidth-1:0] src;
    logic [TdmaAddrWidth-1:0] dst;
    logic [TdmaLenWidth-1:0]  len;
  } tdma_xfer_t;

  typedef struct packed {
    logic [TdmaAddrWidth-1:0] src;
    logic [TdmaAddrWidth-1:0] dst;
    logic [TdmaChunkLenW-1:0] len;
    logic                     last;
  } tdma_chunk_t;

  typedef enum logic {
    TDMA_IDLE  = 1'b0,
    TDMA_SPLIT = 1'b1
  } tdma_split_state_e;

endpackage

// File: rtl/tdma_chunk_len_calc.sv
// Combinational chunk length: min of remaining bytes, max chunk size and the
// room left in the current source and destination pages.
module tdma_chunk_len_calc
  import tdma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned MaxChunkBytes = 256,
  parameter int unsigned PageBytes     = 4096
) (
  input  logic [AddrWidth-1:0]         src_i,
  input  logic [AddrWidth-1:0]         dst_i,
  input  logic [LenWidth-1:0]          remaining_i,
  output logic [$clog2(PageBytes):0]   len_o
);

  localparam int unsigned OffW = $clog2(PageBytes);
  localparam int unsigned LenW = OffW + 1;

  logic [LenW-1:0] src_room;
  logic [LenW-1:0] dst_room;
  logic [LenW-1:0] rem_cap;
  logic [LenW-1:0] page_room;
  logic            unused_addr_hi;

  // Room to the next page boundary is in 1..PageBytes, so LenW bits suffice.
  assign src_room = LenW'(PageBytes) - LenW'(src_i[OffW-1:0]);
  assign dst_room = LenW'(PageBytes) - LenW'(dst_i[OffW-1:0]);

  // MaxChunkBytes <= PageBytes, so clamping the remainder covers the max-chunk term.
  assign rem_cap = (remaining_i > LenWidth'(MaxChunkBytes)) ? LenW'(MaxChunkBytes)
                                                             : LenW'(remaining_i);

  assign page_room = (src_room < dst_room) ? src_room : dst_room;
  assign len_o     = (rem_cap < page_room) ? rem_cap : page_room;

  assign unused_addr_hi = ^{src_i[AddrWidth-1:OffW], dst_i[AddrWidth-1:OffW]};

endmodule

// File: rtl/tdma_burst_splitter.sv
// Splits 1-D tensor-DMA transfers into page-safe chunks of at most MaxChunkBytes
// and pulses done_o once per completed transfer.
module tdma_burst_splitter
  import tdma_pkg::*;
#(
  parameter int unsigned AddrWidth     = 64,
  parameter int unsigned LenWidth      = 32,
  parameter int unsigned MaxChunkBytes = 256,
  parameter int unsigned PageBytes     = 4096
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [AddrWidth-1:0]       req_src_i,
  input  logic [AddrWidth-1:0]       req_dst_i,
  input  logic [LenWidth-1:0]        req_len_i,
  output logic                       chunk_valid_o,
  input  logic                       chunk_ready_i,
  output logic [AddrWidth-1:0]       chunk_src_o,
  output logic [AddrWidth-1:0]       chunk_dst_o,
  output logic [$clog2(PageBytes):0] chunk_len_o,
  output logic                       chunk_last_o,
  output logic                       busy_o,
  output logic                       done_o
);

  localparam int unsigned ChunkLenW = $clog2(PageBytes) + 1;

  tdma_split_state_e state_q, state_d;

  logic [AddrWidth-1:0] cur_src_q, cur_src_d;
  logic [AddrWidth-1:0] cur_dst_q, cur_dst_d;
  logic [LenWidth-1:0]  remaining_q, remaining_d;
  logic                 done_q;
  logic                 done_pending;

  logic [ChunkLenW-1:0] chunk_len;
  logic                 chunk_is_last;
  logic                 req_hs;
  logic                 chunk_hs;
  logic                 req_zero_len;

  tdma_chunk_len_calc #(
    .AddrWidth    (AddrWidth),
    .LenWidth     (LenWidth),
    .MaxChunkBytes(MaxChunkBytes),
    .PageBytes    (PageBytes)
  ) u_len_calc (
    .src_i      (cur_src_q),
    .dst_i      (cur_dst_q),
    .remaining_i(remaining_q),
    .len_o      (chunk_len)
  );

  assign chunk_is_last = (LenWidth'(chunk_len) == remaining_q);
  assign req_zero_len  = (req_len_i == '0);
  assign req_hs        = (state_q == TDMA_IDLE)  && req_valid_i;
  assign chunk_hs      = (state_q == TDMA_SPLIT) && chunk_ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TDMA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TDMA_IDLE: begin
        if (req_valid_i && !req_zero_len) begin
          state_d = TDMA_SPLIT;
        end
      end
      TDMA_SPLIT: begin
        if (chunk_ready_i && chunk_is_last) begin
          state_d = TDMA_IDLE;
        end
      end
    endcase
  end

  // State-decoded outputs; last is masked outside SPLIT so it reads 0 in reset/idle
  always_comb begin
    req_ready_o   = 1'b0;
    chunk_valid_o = 1'b0;
    chunk_last_o  = 1'b0;
    busy_o        = 1'b0;
    unique case (state_q)
      TDMA_IDLE: begin
        req_ready_o = 1'b1;
      end
      TDMA_SPLIT: begin
        chunk_valid_o = 1'b1;
        chunk_last_o  = chunk_is_last;
        busy_o        = 1'b1;
      end
    endcase
  end

  // Transfer cursor: load on request, advance on each chunk handshake
  always_comb begin
    cur_src_d    = cur_src_q;
    cur_dst_d    = cur_dst_q;
    remaining_d  = remaining_q;
    done_pending = 1'b0;
    if (req_hs) begin
      cur_src_d    = req_src_i;
      cur_dst_d    = req_dst_i;
      remaining_d  = req_len_i;
      done_pending = req_zero_len;
    end else if (chunk_hs) begin
      cur_src_d    = cur_src_q + AddrWidth'(chunk_len);
      cur_dst_d    = cur_dst_q + AddrWidth'(chunk_len);
      remaining_d  = remaining_q - LenWidth'(chunk_len);
      done_pending = chunk_is_last;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_src_q   <= '0;
      cur_dst_q   <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      remaining_q <= remaining_d;
      done_q      <= done_pending;
    end
  end

  assign chunk_src_o = cur_src_q;
  assign chunk_dst_o = cur_dst_q;
  assign chunk_len_o = chunk_len;
  assign done_o      = done_q;

endmodule

// File: tb/tb_tdma_burst_splitter.sv
// Self-checking bench for tdma_burst_splitter: directed cases plus random transfers
// compared against a page/chunk arithmetic reference model.
module tb_tdma_burst_splitter;

  localparam int MAXC = 256;
  localparam int PAGE = 4096;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_src_i;
  logic [63:0] req_dst_i;
  logic [31:0] req_len_i;
  logic        chunk_valid_o;
  logic        chunk_ready_i;
  logic [63:0] chunk_src_o;
  logic [63:0] chunk_dst_o;
  logic [12:0] chunk_len_o;
  logic        chunk_last_o;
  logic        busy_o;
  logic        done_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdma_burst_splitter dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_src_i    (req_src_i),
    .req_dst_i    (req_dst_i),
    .req_len_i    (req_len_i),
    .chunk_valid_o(chunk_valid_o),
    .chunk_ready_i(chunk_ready_i),
    .chunk_src_o  (chunk_src_o),
    .chunk_dst_o  (chunk_dst_o),
    .chunk_len_o  (chunk_len_o),
    .chunk_last_o (chunk_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one transfer (caller is in a cycle where the splitter is idle) and
  // follow it to its done pulse; returns in the done cycle.
  task automatic run_xfer(input logic [63:0] src, input logic [63:0] dst,
                          input logic [31:0] len, input int ready_pct);
    logic [63:0] es[$];
    logic [63:0] ed[$];
    int          el[$];
    logic [63:0] s, d;
    logic [31:0] rem;
    int          l, room, idx;
    bit          done_next, fin;

    s = src; d = dst; rem = len;
    while (rem != 0) begin
      l = (rem > 32'(MAXC)) ? MAXC : int'(rem);
      room = PAGE - int'(s % 64'(PAGE));
      if (room < l) l = room;
      room = PAGE - int'(d % 64'(PAGE));
      if (room < l) l = room;
      es.push_back(s); ed.push_back(d); el.push_back(l);
      s = s + 64'(l); d = d + 64'(l); rem = rem - 32'(l);
    end

    chk1("req_ready_before_req", req_ready_o, 1'b1);
    req_valid_i = 1'b1; req_src_i = src; req_dst_i = dst; req_len_i = len;
    step();
    req_valid_i = 1'b0;
    req_src_i = {$urandom, $urandom}; req_dst_i = {$urandom, $urandom}; req_len_i = $urandom;

    idx = 0; done_next = (len == 0); fin = 0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      chk1("done", done_o, done_next);
      if (done_next) begin
        chk1("ready_in_done_cycle", req_ready_o, 1'b1);
        chk1("valid_in_done_cycle", chunk_valid_o, 1'b0);
        chk1("busy_in_done_cycle", busy_o, 1'b0);
        fin = 1;
      end else begin
        chk1("chunk_valid", chunk_valid_o, 1'b1);
        chk1("busy", busy_o, 1'b1);
        chk1("req_ready_busy", req_ready_o, 1'b0);
        chk("chunk_src", chunk_src_o, es[idx]);
        chk("chunk_dst", chunk_dst_o, ed[idx]);
        chk("chunk_len", 64'(chunk_len_o), 64'(el[idx]));
        chk1("chunk_last", chunk_last_o, idx == es.size() - 1);
        chunk_ready_i = ($urandom_range(0, 99) < 32'(ready_pct));
        if (chunk_ready_i) begin
          idx++;
          if (idx == es.size()) done_next = 1;
        end
        step();
      end
    end
    if (!fin) chk1("transfer_timeout", 1'b0, 1'b1);
    chunk_ready_i = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [63:0] rs, rd;
    rst_i = 1'b1; req_valid_i = 1'b0; chunk_ready_i = 1'b0;
    req_src_i = '0; req_dst_i = '0; req_len_i = '0;
    #1;
    chk1("rst_req_ready", req_ready_o, 1'b1);
    chk1("rst_chunk_valid", chunk_valid_o, 1'b0);
    chk1("rst_chunk_last", chunk_last_o, 1'b0);
    chk1("rst_busy", busy_o, 1'b0);
    chk1("rst_done", done_o, 1'b0);
    chk("rst_chunk_src", chunk_src_o, 64'h0);
    chk("rst_chunk_dst", chunk_dst_o, 64'h0);
    chk("rst_chunk_len", 64'(chunk_len_o), 64'h0);
    step(); step();
    rst_i = 1'b0;
    chunk_ready_i = 1'b1;
    step();
    chk1("idle_ready_ignored", chunk_valid_o, 1'b0);

    run_xfer(64'h0, 64'h10000, 32'd600, 100);
    step();
    chk1("single_done_pulse", done_o, 1'b0);
    run_xfer(64'h0FF0, 64'h2000, 32'h40, 100);
    run_xfer(64'h0F80, 64'h1FC0, 32'h100, 100);
    run_xfer(64'h0, 64'h10000, 32'd600, 50);
    step();
    chk1("single_done_pulse_bp", done_o, 1'b0);

    // zero-length, then a second request offered in its done cycle
    run_xfer(64'h3000, 64'h5008, 32'd0, 100);
    run_xfer(64'h3000, 64'h5008, 32'd16, 100);

    // reset in the middle of a 600-byte transfer
    step();
    req_valid_i = 1'b1; req_src_i = 64'h0; req_dst_i = 64'h10000; req_len_i = 32'd600;
    step();
    req_valid_i = 1'b0; chunk_ready_i = 1'b1;
    chk1("mid_first_valid", chunk_valid_o, 1'b1);
    step();
    chk("mid_second_src", chunk_src_o, 64'h100);
    rst_i = 1'b1;
    #1;
    chk1("mid_rst_valid", chunk_valid_o, 1'b0);
    chk1("mid_rst_ready", req_ready_o, 1'b1);
    chk1("mid_rst_busy", busy_o, 1'b0);
    chk1("mid_rst_last", chunk_last_o, 1'b0);
    chk("mid_rst_len", 64'(chunk_len_o), 64'h0);
    step(); step();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("post_rst_no_done", done_o, 1'b0);
      chk1("post_rst_no_valid", chunk_valid_o, 1'b0);
    end
    run_xfer(64'h0F80, 64'h1FC0, 32'h100, 100);

    // silent wrap at the top of the address space
    run_xfer(64'hFFFF_FFFF_FFFF_FFF0, 64'h7FF8, 32'h40, 70);

    for (int t = 0; t < 25; t++) begin
      rs = {$urandom, $urandom};
      rd = {$urandom, $urandom};
      if (t % 2 == 0) begin
        rs[11:0] = 12'($urandom_range(12'hF00, 12'hFFF));
        rd[11:0] = 12'($urandom_range(12'hE00, 12'hFFF));
      end
      if ($urandom_range(0, 3) == 0) step();
      run_xfer(rs, rd, 32'($urandom_range(0, 2000)), int'($urandom_range(30, 100)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
